transition_debouncer: RTL



---
 rtl/transition_debouncer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/transition_debouncer.sv
// transition_debouncer: two-flop synchronizer followed by a four-state
// debounce FSM. The clean level o_out only changes after the synchronized
// input has held a new value for STABLE_CYCLES consecutive cycles; the
// o_rise/o_fall/o_edge strobes are registered and line up with the first
// cycle that o_out shows the new value.
// Optional feature macro: TRANSITION_DEBOUNCER_GLITCH_CNT_EN
//   defined   -> o_glitch_cnt is a saturating count of rejected pulses
//   undefined -> no counter flops, o_glitch_cnt tied to zero
module transition_debouncer #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 16,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_in,
  output logic             o_out,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_edge,
  output logic [CNT_W-1:0] o_glitch_cnt
);

  localparam int unsigned     CW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } state_t;

  localparam state_t RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

  logic          r_s1;
  logic          r_s2;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_out;
  logic          r_rise;
  logic          r_fall;
  logic          r_edge;

`ifdef TRANSITION_DEBOUNCER_GLITCH_CNT_EN
  logic [CNT_W-1:0] r_glitch_cnt;
`endif

  // Bring the raw input into the clock domain; only r_s2 is used downstream.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s1 <= RESET_LEVEL;
      r_s2 <= RESET_LEVEL;
    end else begin
      r_s1 <= i_in;
      r_s2 <= r_s1;
    end
  end

  // Debounce FSM: qualify level changes, emit registered strobes, count rejects.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= RESET_STATE;
      r_cnt   <= '0;
      r_out   <= RESET_LEVEL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_edge  <= 1'b0;
`ifdef TRANSITION_DEBOUNCER_GLITCH_CNT_EN
      r_glitch_cnt <= '0;
`endif
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_edge <= 1'b0;
      case (r_state)
        STABLE_LO, STABLE_HI: begin
          if (r_s2 == r_out) begin
            r_cnt <= '0;
          end else if (STABLE_CYCLES == 1) begin
            // A single-cycle qualification window needs no pending state.
            r_out   <= r_s2;
            r_rise  <= r_s2;
            r_fall  <= ~r_s2;
            r_edge  <= 1'b1;
            r_state <= r_s2 ? STABLE_HI : STABLE_LO;
            r_cnt   <= '0;
          end else begin
            r_state <= r_s2 ? PEND_HI : PEND_LO;
            r_cnt   <= CW'(1);
          end
        end
        PEND_HI, PEND_LO: begin
          if (r_s2 == r_out) begin
            r_state <= r_out ? STABLE_HI : STABLE_LO;
            r_cnt   <= '0;
`ifdef TRANSITION_DEBOUNCER_GLITCH_CNT_EN
            if (r_glitch_cnt != '1)
              r_glitch_cnt <= r_glitch_cnt + 1'b1;
`endif
          end else if (r_cnt == LAST) begin
            r_out   <= r_s2;
            r_rise  <= r_s2;
            r_fall  <= ~r_s2;
            r_edge  <= 1'b1;
            r_state <= r_s2 ? STABLE_HI : STABLE_LO;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= RESET_STATE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_out  = r_out;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
  assign o_edge = r_edge;

`ifdef TRANSITION_DEBOUNCER_GLITCH_CNT_EN
  assign o_glitch_cnt = r_glitch_cnt;
`else
  assign o_glitch_cnt = '0;
`endif

endmodule
